serial_add_ctrl: RTL and testbench

Sequencing controller that performs a WIDTH-bit addition with a single full_adder cell, processing one bit per clock, LSB first. It loads operands on a start request, runs the cell for WIDTH cycles while holding the carry in a flip-flop, then presents the registered result with a one-cycle done pulse. It is the area-minimal adder path for the arithmetic blocks built around full_adder.

---
 rtl/serial_add_pkg.sv | 36 +++
 rtl/serial_add_ctrl_if.sv | 55 +++++
 rtl/serial_add_ctrl_full_adder.sv | 19 +
 rtl/serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - DEFAULT_WIDTH : default operand/result width
//   - state_t       : controller state encoding (2'd3 is treated as IDLE)
//   - clog2()       : counter width helper, never returns less than 1
// Optional feature macro used by the files that import this package:
//   SERIAL_SUB_EN (adds the sub input; see serial_add_ctrl.sv)
// ---------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest n with 2**n >= value, clamped to at least 1 bit so a counter
  // declared from it is always legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle of serial_add_ctrl.
//   start   : request, sampled only while the controller is idle
//   a_in    : operand A (WIDTH bits), captured on acceptance
//   b_in    : operand B (WIDTH bits), captured on acceptance
//   cin_in  : carry-in, captured on acceptance
//   sub     : subtract select, only present with SERIAL_SUB_EN defined
//   busy    : controller is in RUN or DONE
//   done    : one-cycle pulse, sum_out/cout just updated
//   sum_out : registered sum, held until the next result
//   cout    : registered final carry, held with sum_out
// Modports: master drives the request side, slave is the controller.
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

`ifdef SERIAL_SUB_EN
  modport master (
    output start, a_in, b_in, cin_in, sub,
    input  busy, done, sum_out, cout
  );

  modport slave (
    input  start, a_in, b_in, cin_in, sub,
    output busy, done, sum_out, cout
  );
`else
  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout
  );

  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout
  );
`endif

endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell used as the serial datapath.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   carry     : majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial WIDTH-bit adder: one full_adder cell, one bit per clock, LSB
// first. Operands are captured on an accepted start, the cell runs for WIDTH
// cycles with the carry held in a flop, then sum_out/cout are updated and
// done pulses for one cycle. One operation per WIDTH+2 cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_ctrl_if.slave (start, a_in, b_in, cin_in, [sub],
//           busy, done, sum_out, cout)
// Optional feature: SERIAL_SUB_EN - when defined, bus.sub=1 loads ~b_in and a
// carry of 1 (cin_in ignored) so the result is a-b; cout=1 means no borrow.
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = clog2(WIDTH);

  state_t           state_reg;
  state_t           state_next;
  logic             load_en;
  logic             run_en;
  logic             finish_en;

  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             done_reg;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_sum;
  logic             fa_carry;

  // Subtraction is a + ~b + 1, so only the load values differ.
`ifdef SERIAL_SUB_EN
  assign b_load = bus.sub ? ~bus.b_in : bus.b_in;
  assign c_load = bus.sub ? 1'b1 : bus.cin_in;
`else
  assign b_load = bus.b_in;
  assign c_load = bus.cin_in;
`endif

  full_adder u_fa (
    .a     (a_sh_reg[0]),
    .b     (b_sh_reg[0]),
    .cin   (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    run_en     = 1'b0;
    finish_en  = 1'b0;
    case (state_reg)
      ST_RUN: begin
        run_en = 1'b1;
        // The last bit is processed on the same edge that leaves RUN.
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        finish_en  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        // IDLE, and the unused code 2'd3 which behaves as IDLE.
        state_next = ST_IDLE;
        if (bus.start) begin
          load_en    = 1'b1;
          state_next = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      sum_reg    <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      if (load_en) begin
        a_sh_reg  <= bus.a_in;
        b_sh_reg  <= b_load;
        carry_reg <= c_load;
        cnt_reg   <= '0;
      end else if (run_en) begin
        a_sh_reg   <= a_sh_reg >> 1;
        b_sh_reg   <= b_sh_reg >> 1;
        // Sum bits enter at the MSB; after WIDTH shifts bit 0 holds the LSB.
        res_sh_reg <= {fa_sum, res_sh_reg[WIDTH-1:1]};
        carry_reg  <= fa_carry;
        cnt_reg    <= cnt_reg + CW'(1);
      end
      if (finish_en) begin
        sum_reg  <= res_sh_reg;
        cout_reg <= carry_reg;
      end
      done_reg <= finish_en;
    end
  end

  assign bus.busy    = (state_reg == ST_RUN) || (state_reg == ST_DONE);
  assign bus.done    = done_reg;
  assign bus.sum_out = sum_reg;
  assign bus.cout    = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl (WIDTH=8). Expected results come from
// an arithmetic model and are queued at acceptance, then popped on done.
// Define SERIAL_SUB_EN to also exercise subtraction.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests;
  int         fails;
  int         rem;
  int         done_cnt;
  logic [W:0] sb_q[$];
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         sub_v;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.a_in   = a;
    bus.b_in   = b;
    bus.cin_in = cin;
`ifdef SERIAL_SUB_EN
    bus.sub = sub_v;
`endif
  endtask

  task automatic scramble();
    bus.a_in   = W'($urandom);
    bus.b_in   = W'($urandom);
    bus.cin_in = 1'($urandom);
  endtask

  // One clock: update the model at the rising edge, check on the falling edge.
  task automatic tick();
    logic       was_last;
    logic       cur_sub;
    logic [W:0] r;
    @(posedge clk);
    was_last = 1'b0;
    cur_sub  = 1'b0;
`ifdef SERIAL_SUB_EN
    cur_sub = bus.sub;
`endif
    if (!rst_n) begin
      rem = 0;
      sb_q.delete();
      held_sum  = '0;
      held_cout = 1'b0;
    end else if (rem == 0) begin
      if (bus.start) begin
        rem = W + 1;
        sb_q.push_back(model(bus.a_in, bus.b_in, bus.cin_in, cur_sub));
      end
    end else begin
      was_last = (rem == 1);
      rem--;
    end
    @(negedge clk);
    if (bus.done) done_cnt++;
    chk("busy", 64'(bus.busy), 64'(rem != 0));
    chk("done", 64'(bus.done), 64'(was_last));
    if (was_last && sb_q.size() > 0) begin
      r = sb_q.pop_front();
      chk("sum_out", 64'(bus.sum_out), 64'(r[W-1:0]));
      chk("cout", 64'(bus.cout), 64'(r[W]));
      held_sum  = r[W-1:0];
      held_cout = r[W];
    end else begin
      chk("hold_sum", 64'(bus.sum_out), 64'(held_sum));
      chk("hold_cout", 64'(bus.cout), 64'(held_cout));
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, wait for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output int lat);
    drive(a, b, cin);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    scramble();
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      lat++;
      if (bus.done) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    tests     = 0;
    fails     = 0;
    rem       = 0;
    done_cnt  = 0;
    held_sum  = '0;
    held_cout = 1'b0;
    sub_v     = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive('0, '0, 1'b0);

    // Reset state
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sum", 64'(bus.sum_out), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic add and latency
    run_op(8'h3C, 8'h05, 1'b0, lat);
    chk("t1_latency", 64'(lat), 64'(W + 1));
    tick();

    // 2: carry out, then carry-in only
    run_op(8'hFF, 8'h01, 1'b0, lat);
    chk("t2a_latency", 64'(lat), 64'(W + 1));
    run_op(8'h00, 8'h00, 1'b1, lat);
    chk("t2b_latency", 64'(lat), 64'(W + 1));

    // 3: start during RUN is ignored
    drive(8'h10, 8'h20, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    drive(8'hAA, 8'h20, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) tick();
    chk("t3_single_done", 64'(done_cnt - d0), 64'd1);

    // 4: reset mid-RUN, then start sampled on the first edge after release
    run_op(8'h01, 8'h01, 1'b0, lat);
    drive(8'h77, 8'h11, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 64'(bus.busy), 64'd0);
    chk("t4_rst_done", 64'(bus.done), 64'd0);
    chk("t4_rst_sum", 64'(bus.sum_out), 64'd0);
    chk("t4_rst_cout", 64'(bus.cout), 64'd0);
    rem = 0;
    sb_q.delete();
    held_sum  = '0;
    held_cout = 1'b0;
    tick();
    tick();
    drive(8'h01, 8'h02, 1'b0);
    bus.start = 1'b1;
    rst_n = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t4_sum", 64'(bus.sum_out), 64'h03);

    // 5: back-to-back with start held high
    d0 = done_cnt;
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      scramble();
      tick();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_dones", 64'(done_cnt - d0), 64'd3);

`ifdef SERIAL_SUB_EN
    // 6: subtraction
    sub_v = 1'b1;
    run_op(8'h05, 8'h07, 1'b0, lat);
    chk("t6a_sum", 64'(bus.sum_out), 64'hFE);
    chk("t6a_cout", 64'(bus.cout), 64'd0);
    run_op(8'h09, 8'h04, 1'b0, lat);
    chk("t6b_sum", 64'(bus.sum_out), 64'h05);
    chk("t6b_cout", 64'(bus.cout), 64'd1);
    sub_v = 1'b0;
    drive(8'h09, 8'h04, 1'b0);
    tick();
`endif

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
